csr_file_m: RTL and testbench
=============================

# csr_file_m

Parametrised machine-mode CSR file for the single-issue core. It sits beside the register file in the execute/writeback stage and performs CSRRW/CSRRS/CSRRC read-modify-write. It also sequences trap entry (ecall, timer interrupt) and `mret`, and keeps a 64-bit cycle counter. It returns the redirect target to the PC logic in the same cycle the trap or return is requested.

## Interface
Parameters:
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `MSTATUS_RESET`, 32'h1800: reset value of mstatus (MPP=11, MIE=0, MPIE=0).
- `MTVEC_RESET`, 0: reset value of mtvec; bits [1:0] are ignored.
- `HART_ID`, 0: constant returned by mhartid.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid`  in  1  an instruction is at its commit point this cycle.
- `pc`  in  XLEN  PC of that instruction.
- `csr_op`  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear); qualified by `valid`.
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  XLEN  source operand (rs1 value or zero-extended uimm).
- `ecall`  in  1  commit instruction is ecall; qualified by `valid`.
- `mret`  in  1  commit instruction is mret; qualified by `valid`.
- `irq_timer`  in  1  level timer interrupt request.
- `csr_rdata`  out  XLEN  old value of the addressed CSR (combinational).
- `illegal`  out  1  CSR access is illegal this cycle (combinational).
- `redirect`  out  1  PC must be replaced by `redirect_pc` (combinational).
- `redirect_pc`  out  XLEN  trap vector or return address.
- `trap_taken`  out  1  trap (exception or interrupt) is taken this cycle; the core squashes writeback.

## Operation
Implemented CSRs (all other addresses are illegal):
- mstatus 0x300: writable bits are MIE[3] and MPIE[7]. MPP[12:11] reads 11. All other bits read 0.
- mie 0x304: only MTIE[7] is writable.
- mtvec 0x305: direct mode only; bits [1:0] are forced to 0 on write.
- mscratch 0x340: full width.
- mepc 0x341: bits [1:0] are forced to 0.
- mcause 0x342: full width.
- mip 0x344: read-only; MTIP[7] = `irq_timer`.
- mcycle 0xB00: read/write.
- mcycleh 0xB80: read/write; legal only when XLEN=32.
- mhartid 0xF14: read-only.

CSR operations:
- New value: RW → wdata; RS → old | wdata; RC → old & ~wdata.
- RS/RC with `csr_wdata`==0 perform no write and are legal on read-only CSRs.
- `illegal` = valid & csr_op≠00 & (unknown address, or a write to a read-only CSR). When `illegal` is set, no state changes and `csr_rdata`=0.

Event priority per cycle, highest first (all require `valid`):
1. ecall:
   - mepc←pc, mcause←11.
   - MPIE←MIE, MIE←0.
   - redirect_pc=mtvec, trap_taken=1.
2. Interrupt (`irq_timer` & MIE & MTIE):
   - The commit instruction is not executed, and its CSR op is dropped.
   - mepc←pc, mcause←{1, (XLEN-1)'d7}.
   - MPIE←MIE, MIE←0.
   - redirect_pc=mtvec, trap_taken=1.
3. mret:
   - MIE←MPIE, MPIE←1.
   - redirect_pc=mepc, redirect=1, trap_taken=0.
4. CSR op as above.

Other rules:
- `redirect` = trap_taken | mret-taken.
- When `valid`=0, only mcycle advances.
- mcycle (64-bit) increments by 1 every cycle and wraps from 2^64-1 to 0. A CSR write to mcycle or mcycleh that cycle replaces the written half, and the increment is dropped for that cycle only.

## Timing
- Reset values: mstatus=MSTATUS_RESET & writable mask | MPP; mtvec=MTVEC_RESET & ~3; mepc, mcause, mscratch, mie=0; mcycle=0.
- Reset values of outputs: outputs are combinational from the above state, so with `valid`=0 they are all 0.
- `rst` overrides every event in the same edge, including an in-flight trap.
- Reads are zero-latency and return the pre-write value; the new value is visible the cycle after the edge.
- mcycle reads return the value before this cycle's increment.
- A trap or mret affects state at the next rising edge; an interrupt arriving one cycle after an `mret` that re-enabled MIE is taken on the next `valid` cycle.
- Back-to-back CSR ops to the same register need no stall.

## Test plan
- Reset, then read every CSR → mstatus=0x1800, mtvec=0, mhartid=HART_ID, mcycle small; read of 0x7C0 → illegal=1, rdata=0.
- CSRRW mscratch 0xDEADBEEF, then CSRRS with 0x0F, then CSRRC with 0xF0 → rdata sequence: 0, 0xDEADBEEF, 0xDEADBEEF; final value 0xDEADBE0F.
- mtvec←0x80000103, mepc←0x80000006, then ecall at pc=0x80000010 → redirect_pc=0x80000100, mcause=11, mepc=0x80000010, MIE=0. Then mret → redirect_pc=0x80000010, MIE restored.
- irq_timer=1 with MIE=0 → no trap. Set MTIE and MIE → next valid cycle trap_taken=1, mcause=0x80000007, mepc=pc, the concurrent CSRRW is dropped. ecall and irq in the same cycle → mcause=11.
- Write mcycleh=0xFFFFFFFF and mcycle=0xFFFFFFFE → wraps to 0 two cycles later. CSRRW to 0xF14 → illegal=1, value unchanged; CSRRS 0xF14 with 0 → legal.
- Assert `rst` in the same cycle as an ecall → no trap state written; all CSRs at reset values.

Source files
------------

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSRRW/RS/RC, trap entry, mret, 64-bit mcycle.
// Redirect and trap outputs are combinational from state and commit inputs.
module csr_file_m #(
  parameter int              XLEN          = 32,
  parameter logic [31:0]     MSTATUS_RESET = 32'h1800,
  parameter logic [XLEN-1:0] MTVEC_RESET   = '0,
  parameter logic [XLEN-1:0] HART_ID       = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            ecall,
  input  logic            mret,
  input  logic            irq_timer,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_taken
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] MPP_BITS  = XLEN'(32'h1800);
  localparam logic [XLEN-1:0] ALIGN     = ~XLEN'(3);
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11);

  logic            mie_b;
  logic            mpie_b;
  logic            mtie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [63:0]     mcycle;

  logic            known;
  logic            ro;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [63:0]     nv64;
  logic            has_op;
  logic            wr_req;
  logic            ecall_t;
  logic            irq_t;
  logic            mret_t;
  logic            csr_we;
  logic            wr_cyc;
  logic            wr_cych;

  always_comb begin
    known   = 1'b1;
    ro      = 1'b0;
    old_val = '0;
    unique case (csr_addr)
      A_MSTATUS: begin
        old_val    = MPP_BITS;
        old_val[7] = mpie_b;
        old_val[3] = mie_b;
      end
      A_MIE:      old_val[7] = mtie;
      A_MTVEC:    old_val = mtvec;
      A_MSCRATCH: old_val = mscratch;
      A_MEPC:     old_val = mepc;
      A_MCAUSE:   old_val = mcause;
      A_MIP: begin
        ro         = 1'b1;
        old_val[7] = irq_timer;
      end
      A_MCYCLE:   old_val = mcycle[XLEN-1:0];
      A_MCYCLEH: begin
        known   = (XLEN == 32);
        old_val = XLEN'(mcycle[63:32]);
      end
      A_MHARTID: begin
        ro      = 1'b1;
        old_val = HART_ID;
      end
      default:    known = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    unique case (csr_op)
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = old_val | csr_wdata;
      OP_RC:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  assign nv64    = 64'(new_val);
  assign has_op  = valid & (csr_op != 2'b00);
  // RS/RC with a zero operand is a pure read
  assign wr_req  = (csr_op == OP_RW) | (csr_wdata != '0);
  assign illegal = has_op & (~known | (ro & wr_req));
  assign csr_rdata = (has_op & ~illegal) ? old_val : '0;

  assign ecall_t = valid & ecall;
  assign irq_t   = valid & ~ecall & irq_timer & mie_b & mtie;
  assign mret_t  = valid & mret & ~ecall_t & ~irq_t;
  assign csr_we  = has_op & ~illegal & wr_req &
                   ~ecall_t & ~irq_t & ~mret_t;
  assign wr_cyc  = csr_we & (csr_addr == A_MCYCLE);
  assign wr_cych = csr_we & (csr_addr == A_MCYCLEH);

  assign trap_taken = ecall_t | irq_t;
  assign redirect   = trap_taken | mret_t;

  always_comb begin
    redirect_pc = '0;
    unique case (1'b1)
      trap_taken: redirect_pc = mtvec;
      mret_t:     redirect_pc = mepc;
      default:    redirect_pc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_b    <= MSTATUS_RESET[3];
      mpie_b   <= MSTATUS_RESET[7];
      mtie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ALIGN;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
    end else begin
      if (wr_cyc) begin
        if (XLEN == 32) mcycle <= {mcycle[63:32], nv64[31:0]};
        else            mcycle <= nv64;
      end else if (wr_cych) begin
        mcycle <= {nv64[31:0], mcycle[31:0]};
      end else begin
        mcycle <= mcycle + 64'd1;
      end

      if (trap_taken) begin
        mepc   <= pc & ALIGN;
        mcause <= ecall_t ? ECALL_CAUSE : IRQ_CAUSE;
        mpie_b <= mie_b;
        mie_b  <= 1'b0;
      end else if (mret_t) begin
        mie_b  <= mpie_b;
        mpie_b <= 1'b1;
      end else if (csr_we) begin
        unique case (csr_addr)
          A_MSTATUS: begin
            mie_b  <= new_val[3];
            mpie_b <= new_val[7];
          end
          A_MIE:      mtie     <= new_val[7];
          A_MTVEC:    mtvec    <= new_val & ALIGN;
          A_MSCRATCH: mscratch <= new_val;
          A_MEPC:     mepc     <= new_val & ALIGN;
          A_MCAUSE:   mcause   <= new_val;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file_m.sv
// Randomised and directed bench for csr_file_m against a
// behavioural CSR model.
module tb_csr_file_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        ecall;
  logic        mret;
  logic        irq_timer;
  logic [31:0] csr_rdata;
  logic        illegal;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap_taken;

  csr_file_m #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .pc(pc),
    .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .ecall(ecall), .mret(mret),
    .irq_timer(irq_timer), .csr_rdata(csr_rdata),
    .illegal(illegal), .redirect(redirect),
    .redirect_pc(redirect_pc), .trap_taken(trap_taken)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference state, held as architectural register values
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch;
  logic [31:0] m_mepc, m_mcause;
  logic [63:0] m_cycle;

  logic [31:0] last_rd, last_rpc;
  logic        last_ill, last_trap, last_redir;

  logic [11:0] addrs [12] = '{12'h300, 12'h304, 12'h305,
    12'h340, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80,
    12'hF14, 12'h7C0, 12'h123};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mstatus  = 32'h1800;
    m_mie      = 0;
    m_mtvec    = 0;
    m_mscratch = 0;
    m_mepc     = 0;
    m_mcause   = 0;
    m_cycle    = 0;
  endtask

  task automatic model_read(input logic [11:0] a, input logic irq,
                            output logic kn, output logic ro,
                            output logic [31:0] v);
    kn = 1; ro = 0; v = 0;
    case (a)
      12'h300: v = m_mstatus;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: begin ro = 1; v = irq ? 32'h80 : 32'h0; end
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hF14: begin ro = 1; v = 0; end
      default: kn = 0;
    endcase
  endtask

  task automatic model_write(input logic [11:0] a,
                             input logic [31:0] v,
                             output logic cyc_wr);
    cyc_wr = 0;
    case (a)
      12'h300: m_mstatus = (v & 32'h88) | 32'h1800;
      12'h304: m_mie = v & 32'h80;
      12'h305: m_mtvec = v & ~32'h3;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & ~32'h3;
      12'h342: m_mcause = v;
      12'hB00: begin m_cycle[31:0] = v; cyc_wr = 1; end
      12'hB80: begin m_cycle[63:32] = v; cyc_wr = 1; end
      default: ;
    endcase
  endtask

  task automatic step(input logic v, input logic [31:0] p,
                      input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic ec,
                      input logic mr, input logic irq,
                      input logic r);
    logic kn, ro, wr, ill, tec, tirq, tmr, cw;
    logic [31:0] old, nv, erd, epc;
    rst = r; valid = v; pc = p; csr_op = op; csr_addr = a;
    csr_wdata = wd; ecall = ec; mret = mr; irq_timer = irq;
    #2;
    model_read(a, irq, kn, ro, old);
    wr   = (op == 2'b01) || (wd != 0);
    ill  = v && (op != 0) && (!kn || (ro && wr));
    erd  = (v && (op != 0) && !ill) ? old : 32'h0;
    tec  = v && ec;
    tirq = v && !ec && irq && m_mstatus[3] && m_mie[7];
    tmr  = v && mr && !tec && !tirq;
    epc  = (tec || tirq) ? m_mtvec : (tmr ? m_mepc : 32'h0);
    last_rd = csr_rdata; last_ill = illegal;
    last_trap = trap_taken; last_redir = redirect;
    last_rpc = redirect_pc;
    if (!r) begin
      check("rdata", csr_rdata, erd);
      check("illegal", illegal, ill);
      check("trap_taken", trap_taken, tec || tirq);
      check("redirect", redirect, tec || tirq || tmr);
      check("redirect_pc", redirect_pc, epc);
    end
    @(posedge clk); #1;
    if (r) begin
      model_reset();
    end else begin
      cw = 0;
      if (tec || tirq) begin
        m_mepc = p & ~32'h3;
        m_mcause = tec ? 32'd11 : 32'h8000_0007;
        m_mstatus[7] = m_mstatus[3];
        m_mstatus[3] = 0;
      end else if (tmr) begin
        m_mstatus[3] = m_mstatus[7];
        m_mstatus[7] = 1;
      end else if (v && op != 0 && !ill && wr) begin
        case (op)
          2'b01:   nv = wd;
          2'b10:   nv = old | wd;
          default: nv = old & ~wd;
        endcase
        model_write(a, nv, cw);
      end
      if (!cw) m_cycle = m_cycle + 1;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a,
                     input logic [31:0] wd);
    step(1, 32'h100, op, a, wd, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    rst = 1; valid = 0; pc = 0; csr_op = 0; csr_addr = 0;
    csr_wdata = 0; ecall = 0; mret = 0; irq_timer = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // idle outputs after reset
    idle();
    check("rst_rdata", last_rd, 0);
    check("rst_redirect", last_redir, 0);
    for (int i = 0; i < 12; i++) csr(2'b10, addrs[i], 0);
    csr(2'b10, 12'h300, 0);
    check("mstatus_reset", last_rd, 32'h1800);
    csr(2'b10, 12'h7C0, 0);
    check("unknown_illegal", last_ill, 1);
    check("unknown_rdata", last_rd, 0);

    csr(2'b01, 12'h340, 32'hDEADBEEF);
    check("scratch_rw_old", last_rd, 0);
    csr(2'b10, 12'h340, 32'h0F);
    csr(2'b11, 12'h340, 32'hF0);
    check("scratch_rc_old", last_rd, 32'hDEADBEEF);
    csr(2'b10, 12'h340, 0);
    check("scratch_final", last_rd, 32'hDEADBE0F);

    csr(2'b01, 12'h305, 32'h80000103);
    csr(2'b01, 12'h341, 32'h80000006);
    csr(2'b01, 12'h300, 32'h8);
    step(1, 32'h80000010, 0, 0, 0, 1, 0, 0, 0);
    check("ecall_vec", last_rpc, 32'h80000100);
    csr(2'b10, 12'h342, 0);
    check("ecall_cause", last_rd, 11);
    csr(2'b10, 12'h341, 0);
    check("ecall_mepc", last_rd, 32'h80000010);
    csr(2'b10, 12'h300, 0);
    check("ecall_mstatus", last_rd, 32'h1880);
    step(1, 32'h200, 0, 0, 0, 0, 1, 0, 0);
    check("mret_pc", last_rpc, 32'h80000010);
    csr(2'b10, 12'h300, 0);
    check("mret_mstatus", last_rd, 32'h1888);

    csr(2'b11, 12'h300, 32'h8);
    csr(2'b01, 12'h304, 32'h80);
    step(1, 32'h300, 0, 0, 0, 0, 0, 1, 0);
    check("irq_masked", last_trap, 0);
    csr(2'b10, 12'h300, 32'h8);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 32'h444, 2'b01, 12'h340, 32'h1234, 0, 0, 1, 0);
    check("irq_taken", last_trap, 1);
    csr(2'b10, 12'h342, 0);
    check("irq_cause", last_rd, 32'h80000007);
    csr(2'b10, 12'h340, 0);
    check("irq_drop_csr", last_rd, 32'hDEADBE0F);
    csr(2'b10, 12'h300, 32'h8);
    step(1, 32'h500, 0, 0, 0, 1, 0, 1, 0);
    csr(2'b10, 12'h342, 0);
    check("ecall_over_irq", last_rd, 11);

    csr(2'b01, 12'hB80, 32'hFFFFFFFF);
    csr(2'b01, 12'hB00, 32'hFFFFFFFE);
    csr(2'b10, 12'hB00, 0);
    check("cyc_fe", last_rd, 32'hFFFFFFFE);
    csr(2'b10, 12'hB00, 0);
    check("cyc_ff", last_rd, 32'hFFFFFFFF);
    csr(2'b10, 12'hB00, 0);
    check("cyc_wrap", last_rd, 0);
    csr(2'b10, 12'hB80, 0);
    check("cych_wrap", last_rd, 0);

    csr(2'b01, 12'hF14, 32'h5);
    check("hartid_rw_ill", last_ill, 1);
    csr(2'b10, 12'hF14, 0);
    check("hartid_rs0_ok", last_ill, 0);

    step(1, 32'h600, 0, 0, 0, 1, 0, 0, 1);
    csr(2'b10, 12'h342, 0);
    check("rst_cause", last_rd, 0);
    csr(2'b10, 12'h300, 0);
    check("rst_mstatus", last_rd, 32'h1800);
    csr(2'b10, 12'h305, 0);
    check("rst_mtvec", last_rd, 0);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 1) == 0) wd = wd & 32'h8F;
      step($urandom_range(0, 4) != 0, $urandom,
           2'($urandom_range(0, 3)), addrs[$urandom_range(0, 11)],
           wd, $urandom_range(0, 15) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
